// File: rtl/md5_hbf_pkg.sv
// md5_hbf_pkg: shared UART receiver state encoding and framing constants
package md5_hbf_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_state_t;
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;
  localparam int DIGEST_BYTES = 16;
endpackage

// File: rtl/usart_digest_receiver_if.sv
// usart_digest_receiver_if: serial line, rewind control and decoded byte/digest outputs
interface usart_digest_receiver_if import md5_hbf_pkg::*; #(
  parameter int digest_bytes = DIGEST_BYTES
) ();
  logic rxd;
  logic rewind;
  logic [7:0] byte_data;
  logic byte_valid;
  logic frame_error;
  logic [8*digest_bytes-1:0] digest;
  logic digest_valid;
  modport master (output rxd, rewind, input byte_data, byte_valid, frame_error, digest, digest_valid);
  modport slave (input rxd, rewind, output byte_data, byte_valid, frame_error, digest, digest_valid);
endinterface

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 receiver with 2-flop synchroniser, 16x oversampling tick and break handling
module uart_rx_byte import md5_hbf_pkg::*; #(
  parameter int divisor = 27
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_error
);
  localparam int dw = $clog2(divisor + 1);
  localparam logic [dw-1:0] div_last = dw'(divisor - 1);
  localparam logic [3:0] mid_last = 4'(MID_SAMPLE - 1);
  localparam logic [3:0] os_last = 4'(OVERSAMPLE - 1);
  uart_state_t state, state_n;
  logic rxd_m, rxd_s, tick, valid_n, ferr_n;
  logic [dw-1:0] div_cnt, div_n;
  logic [3:0] os_cnt, os_n;
  logic [2:0] bit_idx, bit_n;
  logic [7:0] shift, shift_n, data_n;
  assign tick = div_cnt == div_last;
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      div_cnt <= '0;
      os_cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
      byte_data <= '0;
      byte_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state <= state_n;
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      div_cnt <= div_n;
      os_cnt <= os_n;
      bit_idx <= bit_n;
      shift <= shift_n;
      byte_data <= data_n;
      byte_valid <= valid_n;
      frame_error <= ferr_n;
    end
  always_comb begin
    state_n = state;
    div_n = tick ? '0 : div_cnt + 1'b1;
    os_n = tick ? os_cnt + 4'd1 : os_cnt;
    bit_n = bit_idx;
    shift_n = shift;
    data_n = byte_data;
    valid_n = 1'b0;
    ferr_n = 1'b0;
    case (state)
      IDLE:
        if (!rxd_s) begin
          state_n = START;
          div_n = '0;
          os_n = '0;
        end
      START:
        if (tick && os_cnt == mid_last) begin
          state_n = rxd_s ? IDLE : DATA;
          os_n = '0;
          bit_n = '0;
        end
      DATA:
        if (tick && os_cnt == os_last) begin
          shift_n[bit_idx] = rxd_s;
          os_n = '0;
          bit_n = bit_idx + 3'd1;
          state_n = bit_idx == 3'd7 ? STOP : DATA;
        end
      STOP:
        if (tick && os_cnt == os_last) begin
          state_n = rxd_s ? IDLE : BREAK;
          data_n = rxd_s ? shift : byte_data;
          valid_n = rxd_s;
          ferr_n = !rxd_s;
        end
      BREAK:
        if (rxd_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: rtl/usart_digest_receiver.sv
// usart_digest_receiver: decodes UART bytes and assembles them into an atomically updated digest
module usart_digest_receiver import md5_hbf_pkg::*; #(
  parameter int clock_freq = 50000000,
  parameter int baud_rate = 115200,
  parameter int digest_bytes = DIGEST_BYTES
) (
  input logic clock,
  input logic reset,
  usart_digest_receiver_if.slave bus
);
  localparam int iw = $clog2(digest_bytes + 1);
  localparam logic [iw-1:0] idx_last = iw'(digest_bytes - 1);
  logic [iw-1:0] idx;
  logic [8*digest_bytes-1:0] shadow, shadow_n, digest_q;
  logic done;
  uart_rx_byte #(.divisor(clock_freq / (baud_rate * OVERSAMPLE))) u_rx (
    .clock(clock),
    .reset(reset),
    .rxd(bus.rxd),
    .byte_data(bus.byte_data),
    .byte_valid(bus.byte_valid),
    .frame_error(bus.frame_error)
  );
  assign done = bus.byte_valid && !bus.rewind && idx == idx_last;
  assign bus.digest_valid = done;
  assign bus.digest = done ? shadow_n : digest_q;
  always_comb begin
    shadow_n = shadow;
    shadow_n[8*(digest_bytes - 1 - int'(idx)) +: 8] = bus.byte_data;
  end
  always_ff @(posedge clock)
    if (reset) begin
      idx <= '0;
      shadow <= '0;
      digest_q <= '0;
    end else if (bus.rewind || bus.frame_error) begin
      idx <= '0;
    end else if (bus.byte_valid) begin
      shadow <= shadow_n;
      idx <= done ? '0 : idx + 1'b1;
      if (done) digest_q <= shadow_n;
    end
endmodule

// File: tb/tb_usart_digest_receiver.sv
// tb_usart_digest_receiver: directed checks of byte decode, digest assembly, errors, rewind and reset
module tb_usart_digest_receiver;
  import md5_hbf_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rxd = 1'b1;
  logic rewind = 1'b0;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int bit_clks = 432;
  int t_start = 0;
  int d_bv = 0, d_fe = 0, d_dv = 0, d_cyc = 0;
  int f_bv = 0, f_fe = 0, f_dv = 0, f_odd = 0;
  logic [7:0] d_byte = '0;
  logic [7:0] f_byte = '0;
  logic [127:0] f_digest = '0;
  usart_digest_receiver_if bus_d ();
  usart_digest_receiver_if bus_f ();
  assign bus_d.rxd = rxd;
  assign bus_d.rewind = rewind;
  assign bus_f.rxd = rxd;
  assign bus_f.rewind = rewind;
  usart_digest_receiver dut_d (.clock(clock), .reset(reset), .bus(bus_d));
  usart_digest_receiver #(.clock_freq(3686400)) dut_f (.clock(clock), .reset(reset), .bus(bus_f));
  always #10 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (bus_d.byte_valid) begin
      d_bv++;
      d_byte = bus_d.byte_data;
      d_cyc = cyc;
    end
    if (bus_d.frame_error) d_fe++;
    if (bus_d.digest_valid) d_dv++;
  end
  always @(negedge clock) begin
    if (bus_f.byte_valid) begin
      f_bv++;
      f_byte = bus_f.byte_data;
    end
    if (bus_f.frame_error) f_fe++;
    if (bus_f.digest_valid) begin
      f_dv++;
      f_digest = bus_f.digest;
    end
    if ((bus_f.byte_valid && bus_f.frame_error) || (bus_f.digest_valid && !bus_f.byte_valid)) f_odd++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    t_start = cyc;
    rxd = 1'b0;
    wait_clk(bit_clks);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      wait_clk(bit_clks);
    end
    rxd = stop;
    wait_clk(bit_clks);
    if (stop) wait_clk(bit_clks / 4);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rxd = 1'b1;
    wait_clk(5);
    total++; if (bus_d.byte_data !== 8'h00) begin bad++; $display("FAIL reset_byte_data got %h want 00", bus_d.byte_data); end
    total++; if (bus_d.byte_valid !== 1'b0) begin bad++; $display("FAIL reset_byte_valid got %b want 0", bus_d.byte_valid); end
    total++; if (bus_d.frame_error !== 1'b0) begin bad++; $display("FAIL reset_frame_error got %b want 0", bus_d.frame_error); end
    total++; if (bus_d.digest !== 128'h0) begin bad++; $display("FAIL reset_digest got %h want 0", bus_d.digest); end
    total++; if (bus_d.digest_valid !== 1'b0) begin bad++; $display("FAIL reset_digest_valid got %b want 0", bus_d.digest_valid); end
    total++; if (dut_d.u_rx.state !== IDLE) begin bad++; $display("FAIL reset_state got %0d want IDLE", dut_d.u_rx.state); end
    reset = 1'b0;
    begin
      int b, e, v;
      b = d_bv; e = d_fe; v = d_dv;
      wait_clk(10000);
      total++; if (d_bv - b !== 0) begin bad++; $display("FAIL idle_byte_valid got %0d pulses want 0", d_bv - b); end
      total++; if (d_fe - e !== 0) begin bad++; $display("FAIL idle_frame_error got %0d pulses want 0", d_fe - e); end
      total++; if (d_dv - v !== 0) begin bad++; $display("FAIL idle_digest_valid got %0d pulses want 0", d_dv - v); end
    end
  endtask

  task automatic test_single_byte();
    int b, e, lat;
    bit_clks = 432;
    b = d_bv; e = d_fe;
    send_byte(8'hA5, 1'b1);
    wait_clk(50);
    lat = d_cyc - t_start;
    total++; if (d_bv - b !== 1) begin bad++; $display("FAIL single_count got %0d want 1", d_bv - b); end
    total++; if (d_byte !== 8'hA5) begin bad++; $display("FAIL single_data got %h want a5", d_byte); end
    total++; if (lat < 4104 || lat > 4108) begin bad++; $display("FAIL single_latency got %0d want 4104..4108", lat); end
    total++; if (d_fe - e !== 0) begin bad++; $display("FAIL single_frame_error got %0d want 0", d_fe - e); end
  endtask

  task automatic test_glitch();
    int b, e;
    b = d_bv; e = d_fe;
    rxd = 1'b0;
    wait_clk(100);
    rxd = 1'b1;
    wait_clk(600);
    total++; if (d_bv - b !== 0) begin bad++; $display("FAIL glitch_byte_valid got %0d want 0", d_bv - b); end
    total++; if (d_fe - e !== 0) begin bad++; $display("FAIL glitch_frame_error got %0d want 0", d_fe - e); end
    total++; if (dut_d.u_rx.state !== IDLE) begin bad++; $display("FAIL glitch_state got %0d want IDLE", dut_d.u_rx.state); end
  endtask

  task automatic test_rewind();
    int v;
    bit_clks = 32;
    for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), 1'b1);
    rewind = 1'b1;
    send_byte(8'h55, 1'b1);
    rewind = 1'b0;
    total++; if (f_byte !== 8'h55) begin bad++; $display("FAIL rewind_byte_reported got %h want 55", f_byte); end
    v = f_dv;
    for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i), 1'b1);
    total++; if (f_dv - v !== 1) begin bad++; $display("FAIL rewind_digest_pulses got %0d want 1", f_dv - v); end
    total++; if (f_digest !== 128'h101112131415161718191a1b1c1d1e1f) begin bad++; $display("FAIL rewind_digest got %h want 101112131415161718191a1b1c1d1e1f", f_digest); end
  endtask

  task automatic test_full_digest();
    int b, v;
    b = f_bv; v = f_dv;
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
    total++; if (f_bv - b !== 16) begin bad++; $display("FAIL full_byte_count got %0d want 16", f_bv - b); end
    total++; if (f_dv - v !== 1) begin bad++; $display("FAIL full_digest_pulses got %0d want 1", f_dv - v); end
    total++; if (f_digest !== 128'h000102030405060708090a0b0c0d0e0f) begin bad++; $display("FAIL full_digest got %h want 000102030405060708090a0b0c0d0e0f", f_digest); end
    total++; if (bus_f.digest !== 128'h000102030405060708090a0b0c0d0e0f) begin bad++; $display("FAIL full_digest_hold got %h want 000102030405060708090a0b0c0d0e0f", bus_f.digest); end
    total++; if (f_odd !== 0) begin bad++; $display("FAIL pulse_exclusivity got %0d violations want 0", f_odd); end
  endtask

  task automatic test_frame_error();
    int b, e, v;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    b = f_bv; e = f_fe;
    send_byte(8'h3C, 1'b0);
    wait_clk(2000);
    total++; if (f_fe - e !== 1) begin bad++; $display("FAIL ferr_pulses got %0d want 1", f_fe - e); end
    total++; if (f_bv - b !== 0) begin bad++; $display("FAIL ferr_byte_valid got %0d want 0", f_bv - b); end
    total++; if (bus_f.digest !== 128'h000102030405060708090a0b0c0d0e0f) begin bad++; $display("FAIL ferr_digest_kept got %h want 000102030405060708090a0b0c0d0e0f", bus_f.digest); end
    rxd = 1'b1;
    wait_clk(64);
    v = f_dv;
    for (int i = 0; i < 16; i++) send_byte(8'hF0 + 8'(i), 1'b1);
    total++; if (f_dv - v !== 1) begin bad++; $display("FAIL ferr_next_pulses got %0d want 1", f_dv - v); end
    total++; if (f_digest !== 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff) begin bad++; $display("FAIL ferr_next_digest got %h want f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff", f_digest); end
  endtask

  task automatic test_reset_mid_frame();
    int b, e;
    logic [7:0] d;
    d = 8'hF5;
    b = f_bv; e = f_fe;
    rxd = 1'b0;
    wait_clk(32);
    for (int i = 0; i < 4; i++) begin
      rxd = d[i];
      wait_clk(32);
    end
    rxd = d[4];
    wait_clk(10);
    reset = 1'b1;
    wait_clk(2);
    reset = 1'b0;
    wait_clk(20);
    for (int i = 5; i < 8; i++) begin
      rxd = d[i];
      wait_clk(32);
    end
    rxd = 1'b1;
    wait_clk(72);
    total++; if (f_bv - b !== 0) begin bad++; $display("FAIL midreset_byte_valid got %0d want 0", f_bv - b); end
    total++; if (f_fe - e !== 0) begin bad++; $display("FAIL midreset_frame_error got %0d want 0", f_fe - e); end
    total++; if (bus_f.digest !== 128'h0) begin bad++; $display("FAIL midreset_digest got %h want 0", bus_f.digest); end
    b = f_bv;
    send_byte(8'h3A, 1'b1);
    total++; if (f_bv - b !== 1) begin bad++; $display("FAIL midreset_next_count got %0d want 1", f_bv - b); end
    total++; if (f_byte !== 8'h3A) begin bad++; $display("FAIL midreset_next_data got %h want 3a", f_byte); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_rewind();
    test_full_digest();
    test_frame_error();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
